// File: rtl/lc3_mem_arb_pkg.sv
// Shared types and default widths for the LC3 unified-memory arbiter.
package lc3_mem_arb_pkg;

  localparam int ARB_ADDR_W          = 16;
  localparam int ARB_DATA_W          = 16;
  localparam int ARB_MEM_LAT         = 1;
  localparam int ARB_MAX_DATA_STREAK = 4;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/lc3_arb_streak_ctr.sv
// Counts consecutive data grants that fetch has had to sit through.
// starve goes high once fetch has waited MAX_DATA_STREAK data grants,
// which flips the arbiter's priority to fetch for one grant.
module lc3_arb_streak_ctr #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic data_gnt,
  input  logic fetch_gnt,
  input  logic instr_req,
  output logic starve
);

  localparam int CW = $clog2(MAX_DATA_STREAK + 1);

  logic [CW-1:0] streak;

  // Saturating increment while fetch is waiting; clear on fetch grant or
  // on a data grant that nobody was waiting behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak <= '0;
    end else if (fetch_gnt) begin
      streak <= '0;
    end else if (data_gnt) begin
      if (!instr_req) begin
        streak <= '0;
      end else if (streak != CW'(MAX_DATA_STREAK)) begin
        streak <= streak + CW'(1);
      end
    end
  end

  assign starve = (streak == CW'(MAX_DATA_STREAK));

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the single-port unified LC3 memory between fetch (reads) and
// memaccess (reads/writes). One access in flight at a time; read data comes
// back MEM_LAT cycles after the grant and is passed straight through.
//
// Handshake: a requester holds req (and its address/data) until it sees gnt
// in the same cycle; gnt means the access was issued to memory that cycle.
// rvalid pulses for exactly one cycle per granted read; writes never respond.
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ARB_ADDR_W,
  parameter int DATA_W          = ARB_DATA_W,
  parameter int MEM_LAT         = ARB_MEM_LAT,
  parameter int MAX_DATA_STREAK = ARB_MAX_DATA_STREAK
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_gnt,
  output logic              instr_rvalid,
  output logic [DATA_W-1:0] instr_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_t        dbg_state
);

  localparam int LW = $clog2(MEM_LAT + 1);

  arb_state_t    state;
  arb_owner_t    owner;
  logic [LW-1:0] lat_cnt;
  logic          rst_q;
  logic          starve;
  logic          resp;
  logic          can_grant;
  logic          gnt_d;
  logic          gnt_f;

  // Response cycle: last count of an in-flight read. Suppressed during reset
  // so an interrupted read never produces rvalid.
  assign resp = !reset && (state == ARB_RD_WAIT) && (lat_cnt == LW'(1));

  // rst_q holds off grants for the cycle after reset so all outputs stay 0.
  assign can_grant = !reset && !rst_q && ((state == ARB_IDLE) || resp);
  assign gnt_d     = can_grant && data_req && (!instr_req || !starve);
  assign gnt_f     = can_grant && instr_req && !gnt_d;

  assign instr_gnt = gnt_f;
  assign data_gnt  = gnt_d;

  assign instr_rvalid = resp && (owner == OWN_FETCH);
  assign data_rvalid  = resp && (owner == OWN_DATA);
  assign instr_rdata  = instr_rvalid ? mem_rdata : '0;
  assign data_rdata   = data_rvalid  ? mem_rdata : '0;

  assign dbg_state = state;

  // Drive the memory port from whichever requester won this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (gnt_f) begin
      mem_en   = 1'b1;
      mem_addr = instr_addr;
    end
  end

  // Arbiter FSM: record owner on grant, count down read latency.
  always_ff @(posedge clock) begin
    rst_q <= reset;
    if (reset) begin
      state   <= ARB_IDLE;
      owner   <= OWN_FETCH;
      lat_cnt <= '0;
    end else if (gnt_d || gnt_f) begin
      owner <= gnt_d ? OWN_DATA : OWN_FETCH;
      if (gnt_f || !data_we) begin
        state   <= ARB_RD_WAIT;
        lat_cnt <= LW'(MEM_LAT);
      end else begin
        state   <= ARB_IDLE;
        lat_cnt <= '0;
      end
    end else if (state == ARB_RD_WAIT) begin
      if (resp) begin
        state   <= ARB_IDLE;
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt - LW'(1);
      end
    end
  end

  lc3_arb_streak_ctr #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clock    (clock),
    .reset    (reset),
    .data_gnt (gnt_d),
    .fetch_gnt(gnt_f),
    .instr_req(instr_req),
    .starve   (starve)
  );

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: a MEM_LAT=1 instance and a MEM_LAT=3
// instance share stimulus; each section checks the instance it targets.
module tb_lc3_mem_arbiter;
  import lc3_mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        instr_req, data_req, data_we;
  logic [15:0] instr_addr, data_addr, data_wdata, mem_rdata;

  logic        o1_igt, o1_irv, o1_dgt, o1_drv, o1_en, o1_we;
  logic [15:0] o1_ird, o1_drd, o1_addr, o1_wdata;
  arb_state_t  o1_st;
  logic        o3_igt, o3_irv, o3_dgt, o3_drv, o3_en, o3_we;
  logic [15:0] o3_ird, o3_drd, o3_addr, o3_wdata;
  arb_state_t  o3_st;

  lc3_mem_arbiter #(.MEM_LAT(1), .MAX_DATA_STREAK(4)) dut1 (
    .clock(clock), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(o1_igt),
    .instr_rvalid(o1_irv), .instr_rdata(o1_ird),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(o1_dgt), .data_rvalid(o1_drv),
    .data_rdata(o1_drd), .mem_en(o1_en), .mem_we(o1_we), .mem_addr(o1_addr),
    .mem_wdata(o1_wdata), .mem_rdata(mem_rdata), .dbg_state(o1_st)
  );

  lc3_mem_arbiter #(.MEM_LAT(3), .MAX_DATA_STREAK(4)) dut3 (
    .clock(clock), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(o3_igt),
    .instr_rvalid(o3_irv), .instr_rdata(o3_ird),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(o3_dgt), .data_rvalid(o3_drv),
    .data_rdata(o3_drd), .mem_en(o3_en), .mem_we(o3_we), .mem_addr(o3_addr),
    .mem_wdata(o3_wdata), .mem_rdata(mem_rdata), .dbg_state(o3_st)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // packed view: igt,dgt,en,we,addr,wdata,irv,ird,drv,drd (70 bits)
  function automatic logic [69:0] pk1();
    return {o1_igt, o1_dgt, o1_en, o1_we, o1_addr, o1_wdata,
            o1_irv, o1_ird, o1_drv, o1_drd};
  endfunction

  function automatic logic [69:0] pk3();
    return {o3_igt, o3_dgt, o3_en, o3_we, o3_addr, o3_wdata,
            o3_irv, o3_ird, o3_drv, o3_drd};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                       input logic dw, input logic [15:0] da,
                       input logic [15:0] dd, input logic [15:0] mr);
    instr_req = ir; instr_addr = ia; data_req = dr; data_we = dw;
    data_addr = da; data_wdata = dd; mem_rdata = mr;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  // ---------------- vector table (MEM_LAT = 1 instance) ----------------
  typedef struct {
    logic ir; logic [15:0] ia; logic dr; logic dw;
    logic [15:0] da; logic [15:0] dd; logic [15:0] mr;
    logic e_igt; logic e_dgt; logic e_en; logic e_we;
    logic [15:0] e_addr; logic [15:0] e_wdata;
    logic e_irv; logic [15:0] e_ird; logic e_drv; logic [15:0] e_drd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic b1, b0;
    logic exp_d, prev_d;
    logic [15:0] e;
    b1 = 1'b1; b0 = 1'b0;

    // fields: ir ia dr dw da dd mr | igt dgt en we addr wdata irv ird drv drd
    vecs[0]  = '{b1,16'h3000,b0,b0,16'h0,16'h0,16'h0,  b1,b0,b1,b0,16'h3000,16'h0,b0,16'h0,b0,16'h0};
    vecs[1]  = '{b0,16'h0,b0,b0,16'h0,16'h0,16'h1261,  b0,b0,b0,b0,16'h0,16'h0,b1,16'h1261,b0,16'h0};
    vecs[2]  = '{b0,16'h0,b1,b1,16'h4000,16'hBEEF,16'h0, b0,b1,b1,b1,16'h4000,16'hBEEF,b0,16'h0,b0,16'h0};
    vecs[3]  = '{b0,16'h0,b0,b0,16'h0,16'h0,16'h5555,  b0,b0,b0,b0,16'h0,16'h0,b0,16'h0,b0,16'h0};
    vecs[4]  = '{b0,16'h0,b1,b0,16'h0123,16'h0,16'h0,  b0,b1,b1,b0,16'h0123,16'h0,b0,16'h0,b0,16'h0};
    vecs[5]  = '{b0,16'h0,b1,b0,16'h0124,16'h0,16'hA0A0, b0,b1,b1,b0,16'h0124,16'h0,b0,16'h0,b1,16'hA0A0};
    vecs[6]  = '{b1,16'h3001,b0,b0,16'h0,16'h0,16'h00B1, b1,b0,b1,b0,16'h3001,16'h0,b0,16'h0,b1,16'h00B1};
    vecs[7]  = '{b0,16'h0,b0,b0,16'h0,16'h0,16'h7777,  b0,b0,b0,b0,16'h0,16'h0,b1,16'h7777,b0,16'h0};
    vecs[8]  = '{b1,16'h3002,b1,b1,16'h5000,16'h1234,16'h0, b0,b1,b1,b1,16'h5000,16'h1234,b0,16'h0,b0,16'h0};
    vecs[9]  = '{b1,16'h3002,b0,b0,16'h0,16'h0,16'h0,  b1,b0,b1,b0,16'h3002,16'h0,b0,16'h0,b0,16'h0};
    vecs[10] = '{b0,16'h0,b0,b0,16'h0,16'h0,16'h4444,  b0,b0,b0,b0,16'h0,16'h0,b1,16'h4444,b0,16'h0};
    vecs[11] = '{b0,16'h0,b0,b1,16'h4100,16'hFFFF,16'h0, b0,b0,b0,b0,16'h0,16'h0,b0,16'h0,b0,16'h0};

    // ---- reset: outputs 0 during reset and the cycle after, even with req
    idle();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("reset_cycle_d1", pk1(), 70'h0);
    chk("reset_cycle_d3", pk3(), 70'h0);
    tick();
    reset = 1'b0;
    drive(1'b1, 16'h3000, 1'b1, 1'b0, 16'h4000, 16'h0, 16'h0);
    @(negedge clock);
    chk("post_reset_d1", pk1(), 70'h0);
    chk("post_reset_d3", pk3(), 70'h0);
    tick();

    // ---- table vectors on the MEM_LAT=1 instance
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].dd, vecs[i].mr);
      @(negedge clock);
      chk($sformatf("vec%0d", i), pk1(),
          {vecs[i].e_igt, vecs[i].e_dgt, vecs[i].e_en, vecs[i].e_we,
           vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_irv, vecs[i].e_ird,
           vecs[i].e_drv, vecs[i].e_drd});
      tick();
    end

    // ---- both requesters held, data reads: D D D D F repeating
    prev_d = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_d = ((i % 5) != 4);
      drive(1'b1, 16'h3010, 1'b1, 1'b0, 16'h2000 + 16'(i), 16'h0, 16'h0A00 + 16'(i));
      @(negedge clock);
      chk($sformatf("streak_gnt%0d", i), {68'h0, o1_dgt, o1_igt}, {68'h0, exp_d, !exp_d});
      if (i > 0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        if (prev_d)
          chk($sformatf("streak_drsp%0d", i), {52'h0, o1_drv, o1_irv, o1_drd}, {52'h0, 2'b10, e});
        else
          chk($sformatf("streak_irsp%0d", i), {52'h0, o1_drv, o1_irv, o1_ird}, {52'h0, 2'b01, e});
      end
      exp_q.push_back(16'h0A00 + 16'(i + 1));
      prev_d = exp_d;
      tick();
    end
    exp_q.delete();

    // ---- MEM_LAT=3: data read then queued fetch
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    drive(1'b1, 16'h3100, 1'b1, 1'b0, 16'h6000, 16'h0, 16'h0);
    @(negedge clock);
    chk("l3_T_dgnt", pk3(), {1'b0, 1'b1, 1'b1, 1'b0, 16'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0});
    tick();
    drive(1'b1, 16'h3100, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1111);
    @(negedge clock);
    chk("l3_T1_wait", pk3(), 70'h0);
    tick();
    @(negedge clock);
    chk("l3_T2_wait", pk3(), 70'h0);
    tick();
    mem_rdata = 16'hD00D;
    @(negedge clock);
    chk("l3_T3_rsp_gnt", pk3(), {1'b1, 1'b0, 1'b1, 1'b0, 16'h3100, 16'h0, 1'b0, 16'h0, 1'b1, 16'hD00D});
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h2222);
    @(negedge clock);
    chk("l3_T4_wait", pk3(), 70'h0);
    tick();
    @(negedge clock);
    chk("l3_T5_wait", pk3(), 70'h0);
    tick();
    mem_rdata = 16'hF00D;
    @(negedge clock);
    chk("l3_T6_irsp", pk3(), {1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hF00D, 1'b0, 16'h0});
    tick();

    // ---- MEM_LAT=3: reset during a read (streak was 1 before reset)
    drive(1'b1, 16'h3200, 1'b1, 1'b0, 16'h6100, 16'h0, 16'h0);
    @(negedge clock);
    chk("rst_mid_gnt", {68'h0, o3_dgt, o3_igt}, {68'h0, 2'b10});
    tick();
    idle();
    mem_rdata = 16'h3333;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_reset", pk3(), 70'h0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_after", pk3(), 70'h0);
    tick();
    @(negedge clock);
    chk("rst_mid_no_rsp", pk3(), 70'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h3200, 1'b1, 1'b1, 16'h7000 + 16'(i), 16'(i), 16'h0);
      @(negedge clock);
      chk($sformatf("rst_streak_gnt%0d", i), {68'h0, o3_dgt, o3_igt},
          {68'h0, (i < 4), (i == 4)});
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
